// File: rtl/fifo_v4_sram.sv
// fifo_v4_sram: parametrised synchronous FIFO on an inferred 1-cycle-latency
// RAM, with a 2-entry prefetch stage giving first-word-fall-through output.
// Capacity DEPTH = RAM (DEPTH-2 entries) + 2 prefetch registers.
// Optional macro FIFO_V4_SRAM_ERR_STICKY_EN: makes err_o a sticky flag
// (cleared by reset/flush); otherwise err_o is a 1-cycle pulse.
module fifo_v4_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  err_o
);

  localparam int DEPTH_RAM = DEPTH - 2;
  localparam int PTR_W     = (DEPTH_RAM > 1) ? $clog2(DEPTH_RAM) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH_RAM - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AEMPTY_TH);

  // Storage
  logic [DATA_WIDTH-1:0] mem [DEPTH_RAM];
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic [DATA_WIDTH-1:0] pf0_q, pf0_d, pf1_q, pf1_d;

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
  logic [CNT_W-1:0] usage_q, usage_d;
  logic [1:0]       pf_cnt_q, pf_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             err_q, err_d;

  logic push_acc, pop_acc, byp, ram_wr, rd_issue, err_cond;
  logic [1:0] n;

  // Status outputs come only from registered state
  assign full_o         = (usage_q == DEPTH_C);
  assign empty_o        = (usage_q == '0);
  assign almost_full_o  = (usage_q >= AF_C);
  assign almost_empty_o = (usage_q <= AE_C);
  assign usage_o        = usage_q;
  assign err_o          = err_q;
  assign data_o         = pf0_q;

  // Next-state: prefetch ordering is survivors, then landing RAM word, then bypass push
  always_comb begin
    push_acc  = push_i & ~full_o & ~flush_i;
    pop_acc   = pop_i & ~empty_o & ~flush_i;
    err_cond  = (push_i & full_o) | (pop_i & empty_o);
    pf0_d     = pf0_q;
    pf1_d     = pf1_q;
    n         = pf_cnt_q;
    byp       = 1'b0;
    if (pop_acc) begin
      pf0_d = pf1_q;
      n     = n - 2'd1;
    end
    if (rd_pend_q && !flush_i) begin
      if (n == 2'd0) pf0_d = ram_rdata_q;
      else           pf1_d = ram_rdata_q;
      n = n + 2'd1;
    end
    // Bypass only when nothing older sits in the RAM and a slot is free
    if (push_acc && ram_cnt_q == '0 && n < 2'd2) begin
      byp = 1'b1;
      if (n == 2'd0) pf0_d = data_i;
      else           pf1_d = data_i;
      n = n + 2'd1;
    end
    ram_wr    = push_acc & ~byp;
    // Issue a read whenever a slot will be free for it to land in
    rd_issue  = !flush_i && (ram_cnt_q != '0) && (n < 2'd2);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (ram_wr)   wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_issue) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    ram_cnt_d = ram_cnt_q + CNT_W'(ram_wr) - CNT_W'(rd_issue);
    usage_d   = usage_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    pf_cnt_d  = n;
    rd_pend_d = rd_issue;
`ifdef FIFO_V4_SRAM_ERR_STICKY_EN
    err_d     = err_q | err_cond;
`else
    err_d     = err_cond;
`endif

    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      usage_d   = '0;
      pf_cnt_d  = '0;
      rd_pend_d = 1'b0;
      err_d     = 1'b0;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      usage_q   <= '0;
      pf_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      usage_q   <= usage_d;
      pf_cnt_q  <= pf_cnt_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
    end
  end

  // Prefetch payload registers; contents are don't-care while their slot is empty
  always_ff @(posedge clk_i) begin
    pf0_q <= pf0_d;
    pf1_q <= pf1_d;
  end

  // Inferred RAM: registered read, contents never cleared
  always_ff @(posedge clk_i) begin
    if (ram_wr && rst_ni)   mem[wr_ptr_q] <= data_i;
    if (rd_issue && rst_ni) ram_rdata_q   <= mem[rd_ptr_q];
  end

endmodule

// File: doc/fifo_v4_sram.md
Name: fifo_v4_sram

Overview:
Parametrised synchronous FIFO backed by an inferred single-clock RAM with 1-cycle read latency. It replaces the fixed 32-bit BRAM-macro FIFO.
- Arbitrary DATA_WIDTH and DEPTH.
- First-word-fall-through output through an internal 2-entry prefetch stage.
- Exact occupancy count, programmable almost-full and almost-empty flags.
- Overflow and underflow detection.
Sits between pipeline producers and consumers: load/store queues and trace buffers.

Parameters:
DATA_WIDTH, 32, payload width in bits (1..512)
DEPTH, 16, total entry capacity including the prefetch stage (>=4, any integer, not necessarily a power of 2)
AFULL_TH, DEPTH-2, almost_full_o asserts when usage_o >= AFULL_TH
AEMPTY_TH, 2, almost_empty_o asserts when usage_o <= AEMPTY_TH
CNT_W, $clog2(DEPTH+1), derived; do not override

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset, sampled on the rising edge of clk_i
flush_i  in  1  synchronous clear of all contents
data_i  in  DATA_WIDTH  push payload
push_i  in  1  push request
full_o  out  1  usage_o == DEPTH
almost_full_o  out  1  usage_o >= AFULL_TH
data_o  out  DATA_WIDTH  head entry; valid whenever empty_o == 0
pop_i  in  1  pop request
empty_o  out  1  usage_o == 0
almost_empty_o  out  1  usage_o <= AEMPTY_TH
usage_o  out  CNT_W  exact number of stored entries (RAM + prefetch)
err_o  out  1  overflow/underflow indication (see Optional Feature)

Behaviour:
- Reset (rst_ni=0 at an edge):
  - Read/write pointers, prefetch valid bits and usage counter all go to 0.
  - Outputs after reset: empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=(AFULL_TH==0), usage_o=0, err_o=0.
  - data_o is don't-care while empty.
  - RAM contents are not cleared.
- Accepted push = push_i & ~full_o. Accepted pop = pop_i & ~empty_o. Requests that are not accepted have no effect on state.
- Full and push+pop together: push rejected, pop accepted; usage_o decrements by 1.
- Empty and push+pop together: pop rejected, push accepted; usage_o increments by 1.
- Non-empty, non-full, push+pop together: usage_o unchanged.
- Latency: a push accepted at edge N is visible on data_o with empty_o=0 after edge N (zero-bubble bypass into the prefetch stage when that stage has room). No extra cycle for RAM read.
- Prefetch stage:
  - 2 registers.
  - Refilled from RAM whenever a slot is free or being freed and the RAM is non-empty.
  - The RAM read issued at edge N lands at edge N+1.
  - Back-to-back pops at 1 per cycle must be sustained indefinitely with no bubble while usage_o >= 1.
- Ordering: strict FIFO order across the RAM/bypass paths, including push into an empty FIFO while a RAM read is in flight.
- Pointers: wrap from DEPTH_RAM-1 to 0, where DEPTH_RAM = DEPTH-2. Wrap must be correct for non-power-of-2 depths (explicit compare, no bit truncation).
- Status flags: all registered or derived from registered state only. No combinational path from push_i/pop_i to any status output.
- Flush (flush_i=1 at an edge):
  - Same state effect as reset except err_o, which clears only under the rules in Optional Feature.
  - push_i and pop_i in the same cycle are ignored.
  - An in-flight RAM read is discarded.
- Reset mid-operation: identical to flush, plus err_o=0.
- data_o must hold its value while pop_i=0.

Optional Feature:
Macro FIFO_V4_SRAM_ERR_STICKY_EN.
- Defined:
  - err_o is a sticky flag set on any push_i while full_o=1, or any pop_i while empty_o=1.
  - Cleared only by reset or flush.
  - Assertion at the same edge the offending request is sampled; visible the following cycle.
- Undefined:
  - err_o is a 1-cycle pulse registered from the same condition (visible the cycle after the offending request).
  - Not sticky; cleared by reset and flush.

Test Plan:
- DATA_WIDTH=40, DEPTH=8. After reset, push 0x01..0x08 on consecutive cycles → full_o=1 after the 8th edge, usage_o=8. A 9th push of 0xFF is dropped. Pop 8 times → data_o = 0x01..0x08 in order, empty_o=1.
- Push 0xA5 into an empty FIFO → next cycle empty_o=0, data_o=0xA5. Pop in that cycle → empty_o=1 the following cycle, usage_o=0.
- DEPTH=6 (non-power-of-2). Run continuous push+pop of an incrementing counter for 100 cycles starting at usage 3 → usage_o stays 3, popped sequence is gap-free and increasing, pointer wrap verified.
- Fill to usage_o=5 with DEPTH=8, AFULL_TH=6, AEMPTY_TH=2 → almost_full_o=0. One more push → almost_full_o=1. Pop to usage 2 → almost_empty_o=1.
- Pop while empty → err_o sticky high when FIFO_V4_SRAM_ERR_STICKY_EN is defined, 1-cycle pulse otherwise. Assert flush_i with push_i=1 and 4 entries stored → next cycle usage_o=0, empty_o=1, err_o=0.
- Assert rst_ni=0 for one edge mid-stream at usage 5 with a RAM read in flight → all outputs at reset values. A subsequent push of 0x3C reads back 0x3C, with no stale data.
